// File: rtl/scr1_imem_arb.sv
`default_nettype none
// ============================================================================
// Module   : scr1_imem_arb
// Brief    : Two-port instruction-memory arbiter with in-order response tag
//            FIFO. Define SCR1_IMEM_ARB_RR_EN for round-robin arbitration;
//            otherwise port 0 (IFU) has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module scr1_imem_arb #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_req_i,
    input  logic        s0_cmd_i,
    input  logic [31:0] s0_addr_i,
    output logic        s0_ack_o,
    output logic [31:0] s0_rdata_o,
    output logic [1:0]  s0_resp_o,
    input  logic        s1_req_i,
    input  logic        s1_cmd_i,
    input  logic [31:0] s1_addr_i,
    output logic        s1_ack_o,
    output logic [31:0] s1_rdata_o,
    output logic [1:0]  s1_resp_o,
    output logic        m_req_o,
    output logic        m_cmd_o,
    output logic [31:0] m_addr_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_resp_i,
    output logic        arb_busy_o,
    output logic        arb_err_o
);

    localparam int         c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] c_RESP_ERR = 2'b10;
    localparam logic [1:0] c_RESP_RSV = 2'b11;

    logic [DEPTH-1:0]   r_tag;          // one bit per entry: issuing port id
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_lock_vld;
    logic               r_lock_port;
    logic               r_err;

    logic       w_full;
    logic       w_any_req;
    logic       w_lock_eff;
    logic       w_contend_gnt1;
    logic       w_gnt1;
    logic       w_mreq;
    logic       w_sel1;
    logic       w_push;
    logic       w_rsp_vld;
    logic       w_pop;
    logic       w_head;
    logic       w_err_set;
    logic [1:0] w_rsp_fwd;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_any_req = s0_req_i | s1_req_i;
    // A lock only steers the grant while its owner still requests; a
    // withdrawn request must not leave a phantom grant on the bus.
    assign w_lock_eff = r_lock_vld & (r_lock_port ? s1_req_i : s0_req_i);

`ifdef SCR1_IMEM_ARB_RR_EN
    logic r_last;

    assign w_contend_gnt1 = ~r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_push) begin
            r_last <= w_gnt1;
        end
    end
`else
    assign w_contend_gnt1 = 1'b0;
`endif

    always_comb begin
        w_gnt1 = s1_req_i;
        if (w_lock_eff) begin
            w_gnt1 = r_lock_port;
        end else if (s0_req_i & s1_req_i) begin
            w_gnt1 = w_contend_gnt1;
        end
    end

    assign w_mreq    = w_any_req & ~w_full & ~rst;
    assign w_sel1    = w_mreq & w_gnt1;
    assign w_push    = w_mreq & m_ack_i;
    assign w_rsp_vld = (m_resp_i != 2'b00) & ~rst;
    assign w_pop     = w_rsp_vld & (r_count != '0);
    assign w_head    = r_tag[r_rd_ptr];
    assign w_rsp_fwd = (m_resp_i == c_RESP_RSV) ? c_RESP_ERR : m_resp_i;
    assign w_err_set = w_rsp_vld & ((r_count == '0) | (m_resp_i == c_RESP_RSV));

    assign m_req_o    = w_mreq;
    assign m_cmd_o    = rst ? 1'b0  : (w_sel1 ? s1_cmd_i  : s0_cmd_i);
    assign m_addr_o   = rst ? 32'h0 : (w_sel1 ? s1_addr_i : s0_addr_i);
    assign s0_ack_o   = w_push & ~w_gnt1;
    assign s1_ack_o   = w_push & w_gnt1;
    assign s0_resp_o  = (w_pop & ~w_head) ? w_rsp_fwd : 2'b00;
    assign s1_resp_o  = (w_pop & w_head)  ? w_rsp_fwd : 2'b00;
    assign s0_rdata_o = rst ? 32'h0 : m_rdata_i;
    assign s1_rdata_o = rst ? 32'h0 : m_rdata_i;
    assign arb_busy_o = ~rst & (r_count != '0);
    assign arb_err_o  = ~rst & r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_lock_vld  <= 1'b0;
            r_lock_port <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_push) begin
                r_tag[r_wr_ptr] <= w_gnt1;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            // Hold a stalled request's grant until it is taken or withdrawn.
            if (w_push) begin
                r_lock_vld <= 1'b0;
            end else if (w_mreq & ~m_ack_i) begin
                r_lock_vld  <= 1'b1;
                r_lock_port <= w_gnt1;
            end else if (r_lock_vld & ~w_lock_eff) begin
                r_lock_vld <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
